// File: rtl/adjust_ctrl_multi.sv
// adjust_ctrl_multi: time-set controller for the digital clock.
// Synchronises and debounces the active-low set button, latches the
// highest-priority selected field at the press and emits a one-cycle
// one-hot +1 pulse to that field's counter.
// Optional build macro: AUTO_REPEAT_EN (auto-repeat pulses while held).
module adjust_ctrl_multi #(
  parameter int N_CH       = 3,
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 50,
  parameter int RPT_PERIOD = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sel,
  input  logic            qd,
  input  logic            adj_en,
  output logic [N_CH-1:0] inc,
  output logic            pressed
);

  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DBW = $clog2(DB_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_WAIT_REL
  } state_t;

  logic            r_qd_s1;
  logic            r_qd_s2;
  logic [N_CH-1:0] r_sel_s1;
  logic [N_CH-1:0] r_sel_s2;
  logic [DBW-1:0]  r_db_cnt;
  logic            r_db;
  logic            r_db_d;
  logic [CW-1:0]   r_ch;
  logic            r_pulse;
  state_t          r_state;

  logic            w_qd_lvl;
  logic            w_press_evt;
  logic            w_sel_any;
  logic [CW-1:0]   w_sel_idx;
  state_t          w_state_nxt;
  logic            w_pulse_nxt;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;
  logic [RW-1:0]   r_rpt;
  logic [RW-1:0]   w_rpt_nxt;
`endif

  // Two-flop synchronisers for the button and the select switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qd_s1  <= 1'b1;
      r_qd_s2  <= 1'b1;
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
    end else begin
      r_qd_s1  <= qd;
      r_qd_s2  <= r_qd_s1;
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
    end
  end

  // Button is active-low: a low synchronised level means "held"
  assign w_qd_lvl = ~r_qd_s2;

  // Debounce: accept a new level only after it has differed for DB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
    end else begin
      r_db_d <= r_db;
      if (w_qd_lvl == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
        r_db     <= ~r_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press_evt = r_db & ~r_db_d;
  assign pressed     = r_db;

  // Fixed-priority encoder: highest set select bit wins
  always_comb begin
    w_sel_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (r_sel_s2[i]) w_sel_idx = CW'(i);
    end
  end

  assign w_sel_any = |r_sel_s2;

  // Channel latch at the press event so select changes during a hold are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch <= '0;
    end else if (w_press_evt && (r_state == S_IDLE)) begin
      r_ch <= w_sel_idx;
    end
  end

  // Control FSM state, pulse flag and repeat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rpt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_pulse_nxt;
`ifdef AUTO_REPEAT_EN
      r_rpt   <= w_rpt_nxt;
`endif
    end
  end

  // Next-state and pulse decision
  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
    w_rpt_nxt   = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_press_evt) begin
          if (adj_en && w_sel_any) begin
            w_pulse_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_WAIT_REL;
          end
        end
      end
      S_HOLD: begin
`ifdef AUTO_REPEAT_EN
        w_rpt_nxt = r_rpt + 1'b1;
`endif
        if (!r_db) begin
          w_state_nxt = S_IDLE;
        end else if (!adj_en) begin
          w_state_nxt = S_WAIT_REL;
        end
`ifdef AUTO_REPEAT_EN
        else if (r_rpt == RW'(RPT_DELAY - 1)) begin
          w_pulse_nxt = 1'b1;
          w_rpt_nxt   = '0;
          w_state_nxt = S_REPEAT;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      S_REPEAT: begin
        w_rpt_nxt = r_rpt + 1'b1;
        if (!r_db) begin
          w_state_nxt = S_IDLE;
        end else if (!adj_en) begin
          w_state_nxt = S_WAIT_REL;
        end else if (r_rpt == RW'(RPT_PERIOD - 1)) begin
          w_pulse_nxt = 1'b1;
          w_rpt_nxt   = '0;
        end
      end
`endif
      S_WAIT_REL: begin
        if (!r_db) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulse is decoded from registered flag and latched channel, so at most one bit is high
  assign inc = r_pulse ? (N_CH'(1) << r_ch) : '0;

endmodule

// File: tb/tb_adjust_ctrl_multi.sv
// Scoreboard bench for adjust_ctrl_multi (N_CH=3, DB_CYCLES=4,
// RPT_DELAY=20, RPT_PERIOD=5). Expected pulses are queued with the
// cycle they must appear in; a monitor pops and compares on every pulse.
module tb_adjust_ctrl_multi;

  logic       clk;
  logic       rst;
  logic [2:0] sel;
  logic       qd;
  logic       adj_en;
  logic [2:0] inc;
  logic       pressed;

  int n_checks;
  int n_errors;
  int cyc;
  int g_c0;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  exp_t q[$];

  adjust_ctrl_multi #(
    .N_CH      (3),
    .DB_CYCLES (4),
    .RPT_DELAY (20),
    .RPT_PERIOD(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .qd     (qd),
    .adj_en (adj_en),
    .inc    (inc),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any pulse must match the head of the expectation queue
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL missed_pulse at_cycle=%0d got=none exp=%b", q[0].cyc, q[0].val);
      void'(q.pop_front());
    end
    if (inc !== 3'b000) begin
      n_checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_errors++;
        $display("FAIL unexpected_pulse cycle=%0d got=%b exp=000", cyc, inc);
      end else begin
        if (inc !== q[0].val) begin
          n_errors++;
          $display("FAIL pulse_value cycle=%0d got=%b exp=%b", cyc, inc, q[0].val);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic check_pressed(input string name, input logic exp);
    n_checks++;
    if (pressed !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", name, cyc, pressed, exp);
    end
  endtask

  task automatic push(input int edge_off, input logic [2:0] v);
    exp_t e;
    e.cyc = g_c0 + edge_off;
    e.val = v;
    q.push_back(e);
  endtask

  // qd falls before edge 1 (relative to g_c0)
  task automatic start_press();
    g_c0 = cyc;
    qd   = 1'b0;
  endtask

  // Advance to the negedge following relative edge k
  task automatic wait_to(input int k);
    while (cyc < g_c0 + k) @(negedge clk);
  endtask

  task automatic release_and_settle(input int k);
    wait_to(k);
    qd = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic push_repeats(input logic [2:0] v);
`ifdef AUTO_REPEAT_EN
    push(27, v);
    push(32, v);
    push(37, v);
    push(42, v);
`else
    if (v === 3'bxxx) push(0, v);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    qd       = 1'b0;
    sel      = 3'b111;
    adj_en   = 1'b1;

    // 1. Reset with button held and all selects on
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (inc !== 3'b000 || pressed !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs cycle=%0d got=%b/%b exp=000/0", cyc, inc, pressed);
      end
    end
    rst  = 1'b0;
    g_c0 = cyc;
    @(negedge clk);
    n_checks++;
    if (inc !== 3'b000 || pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset cycle=%0d got=%b/%b exp=000/0", cyc, inc, pressed);
    end
    // Held button after reset is a fresh press with full latency
    push(7, 3'b100);
    wait_to(5);
    check_pressed("rst_hold_pressed_e5", 1'b0);
    wait_to(6);
    check_pressed("rst_hold_pressed_e6", 1'b1);
    release_and_settle(10);

    // 2. Single press on middle field
    sel = 3'b010;
    start_press();
    push(7, 3'b010);
    push_repeats(3'b010);
    wait_to(5);
    check_pressed("t2_pressed_e5", 1'b0);
    wait_to(6);
    check_pressed("t2_pressed_e6", 1'b1);
    wait_to(40);
    qd = 1'b1;
    wait_to(45);
    check_pressed("t2_released_e45", 1'b1);
    wait_to(46);
    check_pressed("t2_released_e46", 1'b0);
    repeat (10) @(negedge clk);

    // 3. Bounces shorter than the debounce window
    repeat (5) begin
      qd = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check_pressed("t3_bounce", 1'b0);
      end
      qd = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_pressed("t3_bounce", 1'b0);
      end
    end
    repeat (6) @(negedge clk);

    // 4a. Priority: bit 2 beats bit 1
    sel = 3'b110;
    start_press();
    push(7, 3'b100);
    release_and_settle(15);

    // 4b. No field selected
    sel = 3'b000;
    start_press();
    wait_to(8);
    check_pressed("t4b_pressed", 1'b1);
    release_and_settle(15);

    // 4c. Adjust disabled at press, enabled mid-hold
    sel    = 3'b001;
    adj_en = 1'b0;
    start_press();
    wait_to(10);
    adj_en = 1'b1;
    release_and_settle(30);

    // 5. Select change during hold is ignored
    sel = 3'b001;
    start_press();
    push(7, 3'b001);
    push_repeats(3'b001);
    wait_to(10);
    sel = 3'b100;
    release_and_settle(40);

    // 6. Long hold on top field
    sel = 3'b100;
    start_press();
    push(7, 3'b100);
    push_repeats(3'b100);
    wait_to(39);
    qd = 1'b1;
    wait_to(44);
    check_pressed("t6_pressed_e44", 1'b1);
    wait_to(45);
    check_pressed("t6_pressed_e45", 1'b0);
    repeat (15) @(negedge clk);

    while (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL pending_pulse at_cycle=%0d got=none exp=%b", q[0].cyc, q[0].val);
      void'(q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
